// File: rtl/oh_pipebuf.sv
// ---------------------------------------------------------------------------
// oh_pipebuf -- elastic pipeline buffer (valid/ready FIFO of DEPTH words)
//
// Purpose:
//   Carries an N-bit word across a valid/ready boundary with up to DEPTH
//   words of storage. in_ready comes from registered state only, so there is
//   no combinational path from out_ready back to in_ready. The first word
//   reaches the output one cycle after it is pushed; nothing passes straight
//   through in the same cycle.
//
// Handshake:
//   A word moves on a rising clk edge when valid and ready are both high
//   (push = in_valid & in_ready, pop = out_valid & out_ready). While
//   out_valid=1 and out_ready=0, out and out_valid hold steady. The buffer
//   samples in only on a push.
//
// Ports:
//   clk        in   1      clock, rising edge
//   reset      in   1      synchronous, active-high
//   in_valid   in   1      upstream word valid
//   in_ready   out  1      buffer can take a word (occupancy < DEPTH)
//   in         in   N      upstream data
//   out_valid  out  1      buffer presents a word (occupancy > 0)
//   out_ready  in   1      downstream takes the word
//   out        out  N      downstream data, 0 while empty
//   count      out  AW     occupancy 0..DEPTH when OH_PIPEBUF_COUNT_EN is
//                          defined, otherwise tied to 0
//
// Build option:
//   OH_PIPEBUF_COUNT_EN -- keeps a full occupancy counter and drives it on
//   count. Without it, only the full/empty flags are kept. The handshake
//   behaves the same in both builds.
// ---------------------------------------------------------------------------
module oh_pipebuf #(
  parameter  int N     = 1,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out,
  output logic [AW-1:0] count
);

  // At least one pointer bit, so the DEPTH=1 case still has a legal vector.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          push, pop;

  // Pointers wrap explicitly at DEPTH-1, so a non-power-of-two DEPTH works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  assign in_ready  = ~full_q;
  assign out_valid = ~empty_q;
  assign push      = in_valid & ~full_q;
  assign pop       = ~empty_q & out_ready;

  // Show 0 while empty, so the stale array contents never reach out.
  assign out = empty_q ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (push) begin
      wr_d = ptr_inc(wr_q);
    end
    if (pop) begin
      rd_d = ptr_inc(rd_q);
    end
    // A push and a pop in the same cycle leave occupancy unchanged. Only a
    // lone push can fill the buffer and only a lone pop can empty it.
    if (push && !pop) begin
      full_d  = (ptr_inc(wr_q) == rd_q);
      empty_d = 1'b0;
    end else if (pop && !push) begin
      full_d  = 1'b0;
      empty_d = (ptr_inc(rd_q) == wr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // The data array has no reset. Its contents are only visible through a
  // valid read pointer. A push in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_q] <= in;
    end
  end

`ifdef OH_PIPEBUF_COUNT_EN
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + AW'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
`else
  assign count = '0;
`endif

endmodule

// File: tb/tb_oh_pipebuf.sv
// ---------------------------------------------------------------------------
// tb_oh_pipebuf -- self-checking bench for oh_pipebuf.
// Four instances share one set of inputs: DEPTH = 2, 4, 3 and 1, all N=8.
// A queue-based reference model (one queue per instance) predicts every
// output after each clock edge. A vector table covers fill/stall/drain on
// the DEPTH=4 instance, and hand-written sequences cover the reset and
// throughput corners.
// ---------------------------------------------------------------------------
module tb_oh_pipebuf;

  localparam int NI = 4;
`ifdef OH_PIPEBUF_COUNT_EN
  localparam bit COUNT_ON = 1'b1;
`else
  localparam bit COUNT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       iv;
  logic       orr;
  logic [7:0] din;
  logic       inr  [NI];
  logic       ov   [NI];
  logic [7:0] dout [NI];
  logic [2:0] cnt  [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DP  = (g == 0) ? 2 : (g == 1) ? 4 : (g == 2) ? 3 : 1;
    localparam int AWG = $clog2(DP + 1);
    logic [AWG-1:0] c;
    oh_pipebuf #(.N(8), .DEPTH(DP)) u_dut (
      .clk      (clk),
      .reset    (rst),
      .in_valid (iv),
      .in_ready (inr[g]),
      .in       (din),
      .out_valid(ov[g]),
      .out_ready(orr),
      .out      (dout[g]),
      .count    (c)
    );
    assign cnt[g] = 3'(c);
  end

  // ---------------- reference model / scoreboard ----------------
  int         dep [NI] = '{2, 4, 3, 1};
  logic [7:0] exp_q [NI][$];
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s dut%0d: got %0h expected %0h at %0t",
                 name, idx, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int occ;
      occ = exp_q[i].size();
      chk("out_valid", i, 32'(ov[i]), 32'(occ > 0));
      chk("in_ready", i, 32'(inr[i]), 32'(occ < dep[i]));
      chk("out", i, 32'(dout[i]), (occ > 0) ? 32'(exp_q[i][0]) : 32'd0);
      chk("count", i, 32'(cnt[i]), COUNT_ON ? 32'(occ) : 32'd0);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set before the call. One rising edge is applied, the model
  // is advanced, and the outputs are compared on the falling edge.
  task automatic step();
    bit push [NI];
    bit pop  [NI];
    for (int i = 0; i < NI; i++) begin
      push[i] = iv && (exp_q[i].size() < dep[i]);
      pop[i]  = orr && (exp_q[i].size() > 0);
    end
    @(posedge clk);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        exp_q[i].delete();
      end else begin
        if (pop[i])  void'(exp_q[i].pop_front());
        if (push[i]) exp_q[i].push_back(din);
      end
    end
    @(negedge clk);
    check_all();
  endtask

  // Fill/stall/drain vectors for the DEPTH=4 instance (dut1).
  typedef struct {
    logic       iv;
    logic [7:0] din;
    logic       orr;
    logic       ov;
    logic       ir;
    logic [7:0] dout;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int pops;
    tbl[0] = '{1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd1};
    tbl[1] = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd2};
    tbl[2] = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 3'd3};
    tbl[3] = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b0, 8'hA0, 3'd4};
    tbl[4] = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b0, 8'hA0, 3'd4};
    tbl[5] = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA1, 3'd3};
    tbl[6] = '{1'b1, 8'hA4, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 3'd0};

    // Reset with in_valid held high: nothing may be stored.
    rst = 1'b1; iv = 1'b1; din = 8'h55; orr = 1'b0;
    step();
    step();
    rst = 1'b0; iv = 1'b0;
    step();
    for (int i = 0; i < NI; i++) begin
      chk("reset_out_valid", i, 32'(ov[i]), 32'd0);
      chk("reset_in_ready", i, 32'(inr[i]), 32'd1);
      chk("reset_count", i, 32'(cnt[i]), 32'd0);
    end

    // DEPTH=2 streaming at full rate: out follows in one cycle later.
    iv = 1'b1; orr = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      din = 8'(k);
      step();
      chk("d2_stream_valid", 0, 32'(ov[0]), 32'd1);
      chk("d2_stream_data", 0, 32'(dout[0]), 32'(k));
      chk("d2_stream_ready", 0, 32'(inr[0]), 32'd1);
    end
    iv = 1'b0;
    repeat (4) step();

    // Table: fill DEPTH=4 to full, stall, then drain in order.
    for (int v = 0; v < 10; v++) begin
      iv = tbl[v].iv; din = tbl[v].din; orr = tbl[v].orr;
      step();
      chk("tbl_out_valid", 1, 32'(ov[1]), 32'(tbl[v].ov));
      chk("tbl_in_ready", 1, 32'(inr[1]), 32'(tbl[v].ir));
      chk("tbl_out", 1, 32'(dout[1]), 32'(tbl[v].dout));
      chk("tbl_count", 1, 32'(cnt[1]), COUNT_ON ? 32'(tbl[v].cnt) : 32'd0);
    end
    iv = 1'b0; orr = 1'b1;
    repeat (5) step();

    // DEPTH=1: one word every two cycles, in_ready = !out_valid.
    iv = 1'b1; orr = 1'b1; pops = 0;
    for (int j = 0; j < 20; j++) begin
      chk("d1_ready_vs_valid", 3, 32'(inr[3]), 32'(!ov[3]));
      if (ov[3]) pops++;
      din = 8'(8'h30 + j);
      step();
    end
    chk("d1_rate", 3, 32'(pops), 32'd10);
    iv = 1'b0;
    repeat (5) step();

    // Reset with two words held in DEPTH=4: they must never appear.
    orr = 1'b0; iv = 1'b1;
    din = 8'hB0; step();
    din = 8'hB1; step();
    iv = 1'b0;
    chk("pre_rst_count", 1, 32'(cnt[1]), COUNT_ON ? 32'd2 : 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_flush_valid", 1, 32'(ov[1]), 32'd0);
    chk("rst_flush_count", 1, 32'(cnt[1]), 32'd0);
    orr = 1'b1;
    repeat (4) begin
      step();
      chk("rst_flush_out", 1, 32'(dout[1]), 32'd0);
      chk("rst_flush_idle", 1, 32'(ov[1]), 32'd0);
    end

    // Random traffic in phases with varying push/pop bias.
    for (int ph = 0; ph < 4; ph++) begin
      int pv, pr;
      pv = (ph == 1) ? 90 : (ph == 2) ? 30 : 60;
      pr = (ph == 1) ? 30 : (ph == 2) ? 90 : 60;
      for (int n = 0; n < 250; n++) begin
        iv  = ($urandom_range(0, 99) < pv);
        orr = ($urandom_range(0, 99) < pr);
        din = 8'($urandom_range(0, 255));
        step();
        chk("d3_count_bound", 2, 32'(cnt[2] <= 3'd3), 32'd1);
      end
    end

    iv = 1'b0; orr = 1'b1;
    repeat (6) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
